// File: rtl/byte_framer_8b.sv
// Packet framer feeding an 8b/10b encoder: wraps a valid/ready byte
// stream in K27.7/K29.7, fills with K28.5, aborts with K30.7.
module byte_framer_8b #(
  parameter int IFG_MIN = 4,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 16
) (
  input  logic             SBYTECLK,
  input  logic             RESET,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [7:0]       o_data8b,
  output logic             o_K,
  output logic             o_abort,
  output logic [CNT_W-1:0] o_frame_cnt
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SOF   = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_EOF   = 3'd3;
  localparam logic [2:0] ST_ABORT = 3'd4;
  localparam logic [2:0] ST_DRAIN = 3'd5;

  localparam logic [7:0] K_IDLE = 8'hBC;
  localparam logic [7:0] K_SOF  = 8'hFB;
  localparam logic [7:0] K_EOF  = 8'hFD;
  localparam logic [7:0] K_ABT  = 8'hFE;

  localparam logic [7:0]       IFG_C = 8'(IFG_MIN);
  localparam logic [LEN_W-1:0] MAX_C = LEN_W'(MAX_LEN);

  logic [2:0]       state_q, state_d;
  logic [7:0]       idle_q, idle_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             last_q, last_d;
  logic             over_q, over_d;
  logic [7:0]       data_q, data_d;
  logic             k_q, k_d;
  logic             abort_q, abort_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [7:0]       idle_inc;
  logic [LEN_W-1:0] len_inc;

  assign idle_inc = (idle_q == 8'hFF) ? idle_q : idle_q + 8'd1;
  assign len_inc  = len_q + LEN_W'(1);

  // Ready depends only on registered state, never on s_valid.
  assign s_ready = (state_q == ST_SOF) | (state_q == ST_DRAIN) |
                   ((state_q == ST_DATA) & ~last_q & ~over_q);

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    len_d   = len_q;
    last_d  = last_q;
    over_d  = over_q;
    cnt_d   = cnt_q;
    data_d  = K_IDLE;
    k_d     = 1'b1;
    abort_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (s_valid && idle_q >= IFG_C) begin
          state_d = ST_SOF;
          data_d  = K_SOF;
          len_d   = '0;
          last_d  = 1'b0;
          over_d  = 1'b0;
        end else begin
          idle_d = idle_inc;
        end
      end
      ST_SOF, ST_DATA: begin
        if (state_q == ST_DATA && last_q) begin
          state_d = ST_EOF;
          data_d  = K_EOF;
          cnt_d   = cnt_q + CNT_W'(1);
        end else if (state_q == ST_DATA && over_q) begin
          state_d = ST_ABORT;
          data_d  = K_ABT;
          abort_d = 1'b1;
        end else if (s_valid) begin
          state_d = ST_DATA;
          data_d  = s_data;
          k_d     = 1'b0;
          len_d   = len_inc;
          last_d  = s_last;
          over_d  = (len_inc == MAX_C) & ~s_last;
        end else begin
          state_d = ST_ABORT;
          data_d  = K_ABT;
          abort_d = 1'b1;
        end
      end
      ST_EOF: begin
        state_d = ST_IDLE;
        idle_d  = 8'd1;
      end
      ST_ABORT: begin
        state_d = ST_DRAIN;
        idle_d  = 8'd1;
      end
      ST_DRAIN: begin
        idle_d = idle_inc;
        if (s_valid && s_last) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge SBYTECLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      idle_q  <= IFG_C;
      len_q   <= '0;
      last_q  <= 1'b0;
      over_q  <= 1'b0;
      data_q  <= K_IDLE;
      k_q     <= 1'b1;
      abort_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      len_q   <= len_d;
      last_q  <= last_d;
      over_q  <= over_d;
      data_q  <= data_d;
      k_q     <= k_d;
      abort_q <= abort_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_data8b    = data_q;
  assign o_K         = k_q;
  assign o_abort     = abort_q;
  assign o_frame_cnt = cnt_q;

endmodule

// File: tb/tb_byte_framer_8b.sv
// Bench for byte_framer_8b: two configurations checked every cycle
// against a character-level model, plus literal stream checks.
module tb_byte_framer_8b;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       hole;
  } item_t;

  typedef struct packed {
    logic [7:0]  ch;
    logic        k;
    logic        ab;
    logic        rdy;
    logic [15:0] cnt;
  } ent_t;

  typedef struct {
    logic [7:0] ch;
    logic       k;
    logic       ab;
    int         gap;
    int         n;
    bit         in_f;
    bit         ended;
    bit         drop;
    int         frames;
  } mdl_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sd0, sd1;
  logic       sv0, sv1, sl0, sl1;
  logic       rdy0, rdy1;
  logic [7:0] d0, d1;
  logic       k0, k1, ab0, ab1;
  logic [1:0]  cnt0;
  logic [15:0] cnt1;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  item_t sq0[$];
  item_t sq1[$];
  ent_t  lg0[$];
  ent_t  lg1[$];
  mdl_t  m0, m1;

  always #5 clk = ~clk;

  byte_framer_8b #(.IFG_MIN(4), .MAX_LEN(8), .CNT_W(2)) u0 (
    .SBYTECLK(clk), .RESET(rst),
    .s_data(sd0), .s_valid(sv0), .s_last(sl0), .s_ready(rdy0),
    .o_data8b(d0), .o_K(k0), .o_abort(ab0), .o_frame_cnt(cnt0)
  );

  byte_framer_8b #(.IFG_MIN(1), .MAX_LEN(1518), .CNT_W(16)) u1 (
    .SBYTECLK(clk), .RESET(rst),
    .s_data(sd1), .s_valid(sv1), .s_last(sl1), .s_ready(rdy1),
    .o_data8b(d1), .o_K(k1), .o_abort(ab1), .o_frame_cnt(cnt1)
  );

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask

  // Character-level rules: what follows the character now on the line.
  function automatic mdl_t mstep(mdl_t m, logic r, logic v,
                                 logic [7:0] d, logic l,
                                 int ifg, int maxl);
    mdl_t x = m;
    int   gi = (m.gap >= 255) ? 255 : m.gap + 1;
    x.ab = 1'b0;
    if (r) begin
      x.ch = 8'hBC; x.k = 1'b1; x.gap = ifg; x.n = 0;
      x.in_f = 0; x.ended = 0; x.drop = 0; x.frames = 0;
    end else if (m.k && m.ch == 8'hFD) begin
      x.ch = 8'hBC; x.gap = 1;
    end else if (m.k && m.ch == 8'hFE) begin
      x.ch = 8'hBC; x.gap = 1; x.drop = 1;
    end else if (m.drop) begin
      x.ch = 8'hBC; x.k = 1'b1; x.gap = gi;
      if (v && l) x.drop = 0;
    end else if (m.in_f) begin
      x.k = 1'b1;
      if (m.ended) begin
        x.ch = 8'hFD; x.in_f = 0; x.frames = m.frames + 1;
      end else if (m.n == maxl || !v) begin
        x.ch = 8'hFE; x.ab = 1'b1; x.in_f = 0;
      end else begin
        x.ch = d; x.k = 1'b0; x.n = m.n + 1; x.ended = l;
      end
    end else if (v && m.gap >= ifg) begin
      x.ch = 8'hFB; x.k = 1'b1; x.in_f = 1; x.n = 0; x.ended = 0;
    end else begin
      x.ch = 8'hBC; x.k = 1'b1; x.gap = gi;
    end
    return x;
  endfunction

  function automatic logic mready(mdl_t m, int maxl);
    return (m.in_f && !m.ended && m.n < maxl) || m.drop;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      m0 = mstep(m0, rst, sv0, sd0, sl0, 4, 8);
      m1 = mstep(m1, rst, sv1, sd1, sl1, 1, 1518);
      #1;
      if (chk_en) begin
        chk("cyc_u0", 32'({rdy0, ab0, k0, d0, 16'(cnt0)}),
            32'({mready(m0, 8), m0.ab, m0.k, m0.ch,
                 16'(m0.frames % 4)}));
        chk("cyc_u1", 32'({rdy1, ab1, k1, d1, cnt1}),
            32'({mready(m1, 1518), m1.ab, m1.k, m1.ch,
                 16'(m1.frames % 65536)}));
        lg0.push_back({d0, k0, ab0, rdy0, 16'(cnt0)});
        lg1.push_back({d1, k1, ab1, rdy1, cnt1});
      end
    end
  end

  task automatic src(ref item_t q[$], input logic r,
                     output logic v, output logic [7:0] d,
                     output logic l);
    v = 1'b0; d = 8'h00; l = 1'b0;
    if (q.size() > 0) begin
      if (q[0].hole) begin
        void'(q.pop_front());
      end else begin
        v = 1'b1; d = q[0].d; l = q[0].last;
        if (r) void'(q.pop_front());
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      src(sq0, rdy0, sv0, sd0, sl0);
      src(sq1, rdy1, sv1, sd1, sl1);
      @(negedge clk);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic l,
                      input logic h);
    sq0.push_back({d, l, h});
    sq1.push_back({d, l, h});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sq0.delete(); sq1.delete();
    sv0 = 1'b0; sv1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    lg0.delete(); lg1.delete();
  endtask

  function automatic int gap_after(ent_t q[$], logic [7:0] code);
    int i = 0;
    int g = 0;
    while (i < q.size() && !(q[i].k && q[i].ch == code)) i++;
    if (i >= q.size()) return -1;
    i++;
    while (i < q.size() && q[i].k && q[i].ch == 8'hBC) begin
      g++; i++;
    end
    if (i >= q.size() || !(q[i].k && q[i].ch == 8'hFB)) return -1;
    return g;
  endfunction

  task automatic ck_ent(input string nm, input ent_t e,
                        input logic k, input logic [7:0] ch);
    chk(nm, 32'({e.k, e.ch}), 32'({k, ch}));
  endtask

  logic [8:0] t1 [6];
  int cnt_a, cnt_b;
  int fdi;
  logic [15:0] fdc [4];

  initial begin
    sv0 = 0; sv1 = 0; sd0 = 0; sd1 = 0; sl0 = 0; sl1 = 0;
    t1 = '{9'h1FB, 9'h011, 9'h022, 9'h033, 9'h1FD, 9'h1BC};
    @(negedge clk);
    do_reset();
    chk_en = 1'b1;
    chk("rst_u0", 32'({rdy0, ab0, k0, d0, 16'(cnt0)}),
        32'({1'b0, 1'b0, 1'b1, 8'hBC, 16'h0}));
    chk("rst_u1", 32'({rdy1, ab1, k1, d1, cnt1}),
        32'({1'b0, 1'b0, 1'b1, 8'hBC, 16'h0}));

    // basic 3-byte frame
    push(8'h11, 0, 0); push(8'h22, 0, 0); push(8'h33, 1, 0);
    run(10);
    for (int i = 0; i < 6; i++)
      ck_ent($sformatf("t1_ch%0d", i), lg0[i], t1[i][8], t1[i][7:0]);
    cnt_a = 0;
    foreach (lg0[i]) cnt_a += int'(lg0[i].rdy);
    chk("t1_ready_cycles", 32'(cnt_a), 32'd3);
    chk("t1_cnt", 32'(lg0[4].cnt), 32'd1);

    // back-to-back frames, gap set by IFG_MIN
    lg0.delete(); lg1.delete();
    push(8'hA1, 0, 0); push(8'hA2, 0, 0); push(8'hA3, 1, 0);
    push(8'hB1, 1, 0);
    run(20);
    chk("t2_gap_ifg4", 32'(gap_after(lg0, 8'hFD)), 32'd4);
    chk("t2_gap_ifg1", 32'(gap_after(lg1, 8'hFD)), 32'd1);
    chk("t2_cnt_u1", 32'(cnt1), 32'd3);

    // underrun after byte 2, remaining bytes drained
    lg0.delete(); lg1.delete();
    push(8'h11, 0, 0); push(8'h22, 0, 0); push(8'h00, 0, 1);
    push(8'h33, 0, 0); push(8'h44, 0, 0); push(8'h55, 0, 0);
    push(8'h66, 1, 0); push(8'h77, 1, 0);
    run(20);
    ck_ent("t3_b1", lg0[1], 1'b0, 8'h11);
    ck_ent("t3_b2", lg0[2], 1'b0, 8'h22);
    ck_ent("t3_fe", lg0[3], 1'b1, 8'hFE);
    chk("t3_abort_bit", 32'(lg0[3].ab), 32'd1);
    cnt_a = 0; cnt_b = 0;
    foreach (lg0[i]) begin
      cnt_a += int'(lg0[i].ab);
      if (!lg0[i].k && lg0[i].ch inside {8'h33, 8'h44, 8'h55, 8'h66})
        cnt_b++;
    end
    chk("t3_abort_once", 32'(cnt_a), 32'd1);
    chk("t3_no_drained", 32'(cnt_b), 32'd0);
    chk("t3_cnt_kept", 32'(lg0[7].cnt), 32'(lg0[0].cnt));
    chk("t3_gap_u0", 32'(gap_after(lg0, 8'hFE)), 32'd5);
    chk("t3_gap_u1", 32'(gap_after(lg1, 8'hFE)), 32'd5);

    // MAX_LEN=8 on u0: oversize truncation, then exact-length frame
    lg0.delete(); lg1.delete();
    for (int i = 1; i <= 10; i++) push(8'(i), i == 10, 0);
    for (int i = 0; i < 8; i++) push(8'hA1 + 8'(i), i == 7, 0);
    run(30);
    ck_ent("t4_sof", lg0[0], 1'b1, 8'hFB);
    for (int i = 0; i < 8; i++)
      ck_ent($sformatf("t4_d%0d", i), lg0[1+i], 1'b0, 8'(i + 1));
    chk("t4_over_nrdy", 32'(lg0[8].rdy), 32'd0);
    ck_ent("t4_fe", lg0[9], 1'b1, 8'hFE);
    chk("t4_fe_ab", 32'(lg0[9].ab), 32'd1);
    chk("t4_gap", 32'(gap_after(lg0, 8'hFE)), 32'd4);
    ck_ent("t4_sof2", lg0[14], 1'b1, 8'hFB);
    for (int i = 0; i < 8; i++)
      ck_ent($sformatf("t4_e%0d", i), lg0[15+i], 1'b0, 8'hA1 + 8'(i));
    ck_ent("t4_eof", lg0[23], 1'b1, 8'hFD);
    cnt_a = 0; cnt_b = 0;
    for (int i = 10; i < lg0.size(); i++) cnt_a += int'(lg0[i].ab);
    foreach (lg0[i])
      if (!lg0[i].k && lg0[i].ch inside {8'h09, 8'h0A}) cnt_b++;
    chk("t4_no_abort2", 32'(cnt_a), 32'd0);
    chk("t4_no_drained", 32'(cnt_b), 32'd0);

    // reset mid-frame
    lg0.delete(); lg1.delete();
    for (int i = 0; i < 5; i++) push(8'h31 + 8'(i), i == 4, 0);
    run(3);
    ck_ent("t5_b2", lg0[2], 1'b0, 8'h32);
    do_reset();
    chk("t5_rst_u0", 32'({rdy0, ab0, k0, d0, 16'(cnt0)}),
        32'({1'b0, 1'b0, 1'b1, 8'hBC, 16'h0}));
    chk("t5_rst_u1", 32'(cnt1), 32'd0);

    // restart, data equal to K codes, counter wrap at CNT_W=2
    push(8'h41, 1, 0); push(8'hBC, 1, 0);
    push(8'hFD, 1, 0); push(8'hFE, 1, 0);
    run(40);
    ck_ent("t5_sof", lg0[0], 1'b1, 8'hFB);
    ck_ent("t5_b", lg0[1], 1'b0, 8'h41);
    ck_ent("t6_bc_data", lg0[8], 1'b0, 8'hBC);
    ck_ent("t6_fd_data", lg0[15], 1'b0, 8'hFD);
    ck_ent("t6_fe_data", lg0[22], 1'b0, 8'hFE);
    chk("t6_fe_data_ab", 32'(lg0[22].ab), 32'd0);
    fdi = 0;
    fdc = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    foreach (lg0[i])
      if (lg0[i].k && lg0[i].ch == 8'hFD && fdi < 4) begin
        fdc[fdi] = lg0[i].cnt; fdi++;
      end
    chk("t6_wrap1", 32'(fdc[0]), 32'd1);
    chk("t6_wrap2", 32'(fdc[1]), 32'd2);
    chk("t6_wrap3", 32'(fdc[2]), 32'd3);
    chk("t6_wrap0", 32'(fdc[3]), 32'd0);
    chk("t6_cnt_u1", 32'(cnt1), 32'd4);
    chk("end_q0_empty", 32'(sq0.size()), 32'd0);
    chk("end_q1_empty", 32'(sq1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
